// File: rtl/data_mem_controller.sv
// Data memory controller: arbitrates load-store unit read/write requests
// onto a single data-memory channel, one transaction at a time, using a
// round-robin pointer that advances past each served consumer.
module data_mem_controller #(
    parameter int unsigned DATA_MEM_ADDR_BITS = 8,
    parameter int unsigned DATA_MEM_DATA_BITS = 8,
    parameter int unsigned NUM_CONSUMERS      = 4
) (
    input  logic                                         clk,
    input  logic                                         reset,

    input  logic [NUM_CONSUMERS-1:0]                     consumer_read_valid,
    input  logic [NUM_CONSUMERS*DATA_MEM_ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                     consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_MEM_DATA_BITS-1:0]  consumer_read_data,

    input  logic [NUM_CONSUMERS-1:0]                     consumer_write_valid,
    input  logic [NUM_CONSUMERS*DATA_MEM_ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_MEM_DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                     consumer_write_ready,

    output logic                                         mem_read_valid,
    output logic [DATA_MEM_ADDR_BITS-1:0]                mem_read_address,
    input  logic                                         mem_read_ready,
    input  logic [DATA_MEM_DATA_BITS-1:0]                mem_read_data,

    output logic                                         mem_write_valid,
    output logic [DATA_MEM_ADDR_BITS-1:0]                mem_write_address,
    output logic [DATA_MEM_DATA_BITS-1:0]                mem_write_data,
    input  logic                                         mem_write_ready
);

    localparam int unsigned AW = DATA_MEM_ADDR_BITS;
    localparam int unsigned DW = DATA_MEM_DATA_BITS;
    localparam int unsigned NC = NUM_CONSUMERS;
    localparam int unsigned PW = (NC > 1) ? $clog2(NC) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        RELEASE    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic            is_read_q, is_read_d;

    logic            mem_read_valid_q, mem_read_valid_d;
    logic [AW-1:0]   mem_read_address_q, mem_read_address_d;
    logic            mem_write_valid_q, mem_write_valid_d;
    logic [AW-1:0]   mem_write_address_q, mem_write_address_d;
    logic [DW-1:0]   mem_write_data_q, mem_write_data_d;

    logic [NC-1:0]   read_ready_q, read_ready_d;
    logic [NC-1:0]   write_ready_q, write_ready_d;
    logic [DW-1:0]   rd_data_q [NC];
    logic [DW-1:0]   rd_data_d [NC];

    logic [AW-1:0]   rd_addr [NC];
    logic [AW-1:0]   wr_addr [NC];
    logic [DW-1:0]   wr_data [NC];

    logic [NC-1:0]   requesting;
    logic            pick_found;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   cand;
    logic            served_dropped;

    // Unpack per-consumer request fields and pack returned read data
    genvar g;
    generate
        for (g = 0; g < NC; g++) begin : g_slices
            assign rd_addr[g] = consumer_read_address[g*AW +: AW];
            assign wr_addr[g] = consumer_write_address[g*AW +: AW];
            assign wr_data[g] = consumer_write_data[g*DW +: DW];
            assign consumer_read_data[g*DW +: DW] = rd_data_q[g];
        end
    endgenerate

    assign requesting = consumer_read_valid | consumer_write_valid;

    // Round-robin pick: first requester at or above rr_ptr, wrapping
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < NC; i++) begin
            cand = PW'((32'(rr_ptr_q) + i) % NC);
            if (!pick_found && requesting[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // The served direction of the granted consumer has been released
    always_comb begin
        served_dropped = is_read_q ? !consumer_read_valid[grant_q]
                                   : !consumer_write_valid[grant_q];
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d             = state_q;
        rr_ptr_d            = rr_ptr_q;
        grant_d             = grant_q;
        is_read_d           = is_read_q;
        mem_read_valid_d    = mem_read_valid_q;
        mem_read_address_d  = mem_read_address_q;
        mem_write_valid_d   = mem_write_valid_q;
        mem_write_address_d = mem_write_address_q;
        mem_write_data_d    = mem_write_data_q;
        read_ready_d        = read_ready_q;
        write_ready_d       = write_ready_q;
        rd_data_d           = rd_data_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    if (consumer_read_valid[pick_idx]) begin
                        is_read_d          = 1'b1;
                        mem_read_address_d = rd_addr[pick_idx];
                        mem_read_valid_d   = 1'b1;
                        state_d            = READ_WAIT;
                    end else begin
                        is_read_d           = 1'b0;
                        mem_write_address_d = wr_addr[pick_idx];
                        mem_write_data_d    = wr_data[pick_idx];
                        mem_write_valid_d   = 1'b1;
                        state_d             = WRITE_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (mem_read_ready) begin
                    rd_data_d[grant_q]    = mem_read_data;
                    read_ready_d[grant_q] = 1'b1;
                    mem_read_valid_d      = 1'b0;
                    state_d               = RELEASE;
                end
            end
            WRITE_WAIT: begin
                if (mem_write_ready) begin
                    write_ready_d[grant_q] = 1'b1;
                    mem_write_valid_d      = 1'b0;
                    state_d                = RELEASE;
                end
            end
            RELEASE: begin
                if (served_dropped) begin
                    read_ready_d  = '0;
                    write_ready_d = '0;
                    rr_ptr_d      = (grant_q == PW'(NC - 1)) ? '0 : grant_q + PW'(1);
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q             <= IDLE;
            rr_ptr_q            <= '0;
            grant_q             <= '0;
            is_read_q           <= 1'b0;
            mem_read_valid_q    <= 1'b0;
            mem_read_address_q  <= '0;
            mem_write_valid_q   <= 1'b0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
            read_ready_q        <= '0;
            write_ready_q       <= '0;
            for (int unsigned i = 0; i < NC; i++) begin
                rd_data_q[i] <= '0;
            end
        end else begin
            state_q             <= state_d;
            rr_ptr_q            <= rr_ptr_d;
            grant_q             <= grant_d;
            is_read_q           <= is_read_d;
            mem_read_valid_q    <= mem_read_valid_d;
            mem_read_address_q  <= mem_read_address_d;
            mem_write_valid_q   <= mem_write_valid_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_data_q    <= mem_write_data_d;
            read_ready_q        <= read_ready_d;
            write_ready_q       <= write_ready_d;
            rd_data_q           <= rd_data_d;
        end
    end

    assign consumer_read_ready  = read_ready_q;
    assign consumer_write_ready = write_ready_q;
    assign mem_read_valid       = mem_read_valid_q;
    assign mem_read_address     = mem_read_address_q;
    assign mem_write_valid      = mem_write_valid_q;
    assign mem_write_address    = mem_write_address_q;
    assign mem_write_data       = mem_write_data_q;

endmodule
